// File: rtl/mole_generator_rng.sv
// ----------------------------------------------------------------------------
// mole_generator_rng
//   Picks three distinct holes (0..17) on each rising edge of the slow game
//   tick. The picks are drawn from a free-running 16-bit Galois LFSR.
//
//   Ports:
//     clk            in   system clock
//     rst_n          in   asynchronous active-low reset
//     mole_clk       in   slow game tick (level, asynchronous to clk)
//     mole_positions out  18-bit hole mask, one bit per occupied hole
//     mole_position1 out  hole index of mole 1 (31 = none)
//     mole_position2 out  hole index of mole 2 (31 = none)
//     mole_position3 out  hole index of mole 3 (31 = none)
//
//   Build option:
//     MOLE_GEN_NO_REPEAT_EN  when defined, a new set never reuses a hole from
//                            the previous set.
// ----------------------------------------------------------------------------
module mole_generator_rng (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mole_clk,
    output logic [17:0] mole_positions,
    output logic [4:0]  mole_position1,
    output logic [4:0]  mole_position2,
    output logic [4:0]  mole_position3
);

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [4:0]  NONE      = 5'd31;

    logic [15:0] lfsr_q, lfsr_d;
    logic        s1_q, s2_q, s3_q;
    logic        tick;
    logic [4:0]  pos1_q, pos2_q, pos3_q;
    logic [17:0] mask_q;
    logic [4:0]  c1, c2, c3;
    logic [4:0]  pv1, pv2, pv3;
    logic [4:0]  p1, p2, p3;
    logic [17:0] mask_d;

    function automatic logic [4:0] mod18(input logic [7:0] v);
        return 5'(v % 8'd18);
    endfunction

    function automatic logic [4:0] inc18(input logic [4:0] v);
        return (v == 5'd17) ? 5'd0 : v + 5'd1;
    endfunction

    // Bump the candidate until it hits none of the five excluded holes.
    // Five exclusions can never need more than five steps; once the value is
    // free, further iterations leave it alone. NONE (31) never matches.
    function automatic logic [4:0] resolve(input logic [4:0] c,
                                           input logic [4:0] x0, input logic [4:0] x1,
                                           input logic [4:0] x2, input logic [4:0] x3,
                                           input logic [4:0] x4);
        logic [4:0] v;
        v = c;
        for (int i = 0; i < 5; i++) begin
            if (v == x0 || v == x1 || v == x2 || v == x3 || v == x4)
                v = inc18(v);
        end
        return v;
    endfunction

    // Galois LFSR, runs every cycle.
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);

    // s3 holds last s2 so a long high level yields a single tick.
    assign tick = s2_q & ~s3_q;

    assign c1 = mod18(lfsr_q[7:0]);
    assign c2 = mod18(lfsr_q[15:8]);
    assign c3 = mod18(lfsr_q[11:4]);

`ifdef MOLE_GEN_NO_REPEAT_EN
    assign pv1 = pos1_q;
    assign pv2 = pos2_q;
    assign pv3 = pos3_q;
`else
    assign pv1 = NONE;
    assign pv2 = NONE;
    assign pv3 = NONE;
`endif

    assign p1 = resolve(c1, NONE, NONE, pv1, pv2, pv3);
    assign p2 = resolve(c2, p1,   NONE, pv1, pv2, pv3);
    assign p3 = resolve(c3, p1,   p2,   pv1, pv2, pv3);

    assign mask_d = (18'd1 << p1) | (18'd1 << p2) | (18'd1 << p3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            pos1_q <= NONE;
            pos2_q <= NONE;
            pos3_q <= NONE;
            mask_q <= 18'h0;
        end else begin
            lfsr_q <= lfsr_d;
            s1_q   <= mole_clk;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            if (tick) begin
                pos1_q <= p1;
                pos2_q <= p2;
                pos3_q <= p3;
                mask_q <= mask_d;
            end
        end
    end

    assign mole_positions = mask_q;
    assign mole_position1 = pos1_q;
    assign mole_position2 = pos2_q;
    assign mole_position3 = pos3_q;

endmodule

// File: tb/tb_mole_generator_rng.sv
// ----------------------------------------------------------------------------
// tb_mole_generator_rng
//   Directed bench for mole_generator_rng. Hand-computed first set after
//   reset release (LFSR 16'h7138 -> holes 2, 5, 1, mask 18'h26) plus an
//   independent LFSR/mod-18 reference for later ticks.
// ----------------------------------------------------------------------------
module tb_mole_generator_rng;

    logic        clk;
    logic        rst_n;
    logic        mole_clk;
    logic [17:0] mole_positions;
    logic [4:0]  mole_position1, mole_position2, mole_position3;

    int n_cmp = 0;
    int n_err = 0;

    mole_generator_rng dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mole_clk       (mole_clk),
        .mole_positions (mole_positions),
        .mole_position1 (mole_position1),
        .mole_position2 (mole_position2),
        .mole_position3 (mole_position3)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Reference LFSR; m_prev is the value the DUT used on the last edge.
    logic [15:0] m, m_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m      <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m      <= {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0);
            m_prev <= m;
        end
    end

    int          ep1, ep2, ep3;
    logic [17:0] emask;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [15:0] l, input int q1, input int q2, input int q3,
                         output int r1, output int r2, output int r3);
        r1 = l[7:0] % 18;
        while (r1 == q1 || r1 == q2 || r1 == q3) r1 = (r1 + 1) % 18;
        r2 = l[15:8] % 18;
        while (r2 == r1 || r2 == q1 || r2 == q2 || r2 == q3) r2 = (r2 + 1) % 18;
        r3 = l[11:4] % 18;
        while (r3 == r1 || r3 == r2 || r3 == q1 || r3 == q2 || r3 == q3) r3 = (r3 + 1) % 18;
    endtask

    function automatic logic [32:0] snap();
        return {mole_positions, mole_position1, mole_position2, mole_position3};
    endfunction

    // Called at a negedge. Raises mole_clk for hi cycles, lowers it for lo.
    task automatic tick_chk(input int hi, input int lo, input bit hand);
        logic [32:0] old;
        int          r1, r2, r3, chg;
        logic [17:0] nm;
        bit          ok;
        old = snap();
        mole_clk = 1'b1;
        @(posedge clk);           // E0
        @(negedge clk);
        @(posedge clk);           // E1
        @(negedge clk);
        chk("pre_hold", {31'd0, snap()}, {31'd0, old});
        @(posedge clk);           // E2
        @(negedge clk);
`ifdef MOLE_GEN_NO_REPEAT_EN
        model(m_prev, ep1, ep2, ep3, r1, r2, r3);
`else
        model(m_prev, 31, 31, 31, r1, r2, r3);
`endif
        nm = 18'h0;
        nm[r1] = 1'b1;
        nm[r2] = 1'b1;
        nm[r3] = 1'b1;
        chk("p1", mole_position1, r1);
        chk("p2", mole_position2, r2);
        chk("p3", mole_position3, r3);
        chk("mask", mole_positions, nm);
        chk("popcnt", $countones(mole_positions), 3);
        ok = mole_position1 < 18 && mole_position2 < 18 && mole_position3 < 18 &&
             mole_position1 != mole_position2 && mole_position1 != mole_position3 &&
             mole_position2 != mole_position3;
        chk("valid", ok, 1);
`ifdef MOLE_GEN_NO_REPEAT_EN
        if (emask != 18'h0) chk("no_repeat", mole_positions & emask, 0);
`endif
        if (hand) begin
            chk("hand_p1", mole_position1, 2);
            chk("hand_p2", mole_position2, 5);
            chk("hand_p3", mole_position3, 1);
            chk("hand_mask", mole_positions, 18'h26);
        end
        ep1 = r1; ep2 = r2; ep3 = r3; emask = nm;
        old = snap();
        chg = 0;
        for (int i = 3; i < hi; i++) begin
            @(negedge clk);
            if (snap() !== old) chg++;
        end
        mole_clk = 1'b0;
        for (int i = 0; i < lo; i++) begin
            @(negedge clk);
            if (snap() !== old) chg++;
        end
        chk("hold", chg, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_p1"}, mole_position1, 31);
        chk({tag, "_p2"}, mole_position2, 31);
        chk({tag, "_p3"}, mole_position3, 31);
        chk({tag, "_mask"}, mole_positions, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        mole_clk = 1'b0;
        ep1 = 31; ep2 = 31; ep3 = 31; emask = 18'h0;
        repeat (4) @(negedge clk);
        chk_reset("rst");

        // mole_clk already high at release: update on third edge.
        rst_n    = 1'b1;
        tick_chk(4, 4, 1'b1);

        for (int k = 0; k < 10; k++) tick_chk(4, 4, 1'b0);

        // Long high level: exactly one update.
        tick_chk(50, 4, 1'b0);

        // Asynchronous reset between ticks.
        #20 rst_n = 1'b0;
        #1 chk_reset("midrst");
        ep1 = 31; ep2 = 31; ep3 = 31; emask = 18'h0;
        @(negedge clk);
        chk_reset("midrst_hold");
        rst_n = 1'b1;
        tick_chk(4, 4, 1'b1);
        for (int k = 0; k < 3; k++) tick_chk(4, 4, 1'b0);

`ifdef MOLE_GEN_NO_REPEAT_EN
        for (int k = 0; k < 100; k++) tick_chk(3, 3, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #20ms;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
